// File: rtl/mrc_sign_ec_resolve.sv
// Sign-pair resolver for the MRC digit-5..9 pipeline: classifies A/B sign agreement,
// buffers results in a small FIFO, counts errors/drops and issues rate-limited retries.
module mrc_sign_ec_resolve #(
   parameter int DATA_WIDTH = 18,
   parameter int TAG_WIDTH  = 8,
   parameter int FIFO_AW    = 3,
   parameter int CNT_WIDTH  = 16,
   parameter int RETRY_GAP  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] d4_0_8_,
   input  logic [1:0]            Sgn_in_9_A,
   input  logic [1:0]            Sgn_in_9_B,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   input  logic                  clr_cnt,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_digit,
   output logic [1:0]            out_sign,
   output logic [1:0]            out_err,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  retry_req,
   output logic [TAG_WIDTH-1:0]  retry_tag,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic                  ovf_sticky
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = DATA_WIDTH + TAG_WIDTH + 4;
   localparam int GW    = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   logic [1:0]            cls_sign, cls_err;
   logic                  c_valid;
   logic [1:0]            c_sign, c_err;
   logic [DATA_WIDTH-1:0] c_digit;
   logic [TAG_WIDTH-1:0]  c_tag;
   logic [EW-1:0]         mem [DEPTH];
   logic [EW-1:0]         head;
   logic [FIFO_AW:0]      wr_ptr, rd_ptr, occ;
   logic                  full, pop, do_push, drop, err_ev;
   state_t                state, state_d;
   logic [GW-1:0]         gap, gap_d;
   logic                  fire;

   always_comb begin
      cls_sign = Sgn_in_9_A;
      cls_err  = 2'b00;
      if (Sgn_in_9_A != Sgn_in_9_B) begin
         cls_sign = 2'b11;
         cls_err  = 2'b01;
      end else if (Sgn_in_9_A == 2'b11) begin
         cls_err  = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_valid <= 1'b0;
         c_sign  <= '0;
         c_err   <= '0;
         c_digit <= '0;
         c_tag   <= '0;
      end else begin
         c_valid <= in_valid;
         if (in_valid) begin
            c_sign  <= cls_sign;
            c_err   <= cls_err;
            c_digit <= d4_0_8_;
            c_tag   <= tag_in;
         end
      end
   end

   // Extra pointer bit distinguishes full from empty; outputs are gated so they read 0 when empty.
   assign occ       = wr_ptr - rd_ptr;
   assign full      = occ[FIFO_AW];
   assign out_valid = (occ != '0);
   assign pop       = out_valid && out_ready;
   assign do_push   = c_valid && (!full || pop);
   assign drop      = c_valid && full && !pop;
   assign head      = mem[rd_ptr[FIFO_AW-1:0]];
   assign out_digit = out_valid ? head[EW-1 -: DATA_WIDTH] : '0;
   assign out_tag   = out_valid ? head[TAG_WIDTH+3 -: TAG_WIDTH] : '0;
   assign out_sign  = out_valid ? head[3:2] : '0;
   assign out_err   = out_valid ? head[1:0] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= {c_digit, c_tag, c_sign, c_err};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                     input logic ev, input logic clr);
      if (clr)           return CNT_WIDTH'(ev);
      if (ev && c != '1) return c + CNT_WIDTH'(1);
      return c;
   endfunction

   assign err_ev = in_valid && (cls_err != 2'b00);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count  <= '0;
         drop_count <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         err_count  <= cnt_next(err_count, err_ev, clr_cnt);
         drop_count <= cnt_next(drop_count, drop, clr_cnt);
         ovf_sticky <= clr_cnt ? drop : (ovf_sticky | drop);
      end
   end

   always_comb begin
      state_d = state;
      gap_d   = gap;
      fire    = 1'b0;
      case (state)
         IDLE: if (c_valid && c_err == 2'b01) begin
            fire    = 1'b1;
            state_d = HOLD;
            gap_d   = GW'(RETRY_GAP - 1);
         end
         HOLD: begin
            if (gap == '0) state_d = IDLE;
            else           gap_d   = gap - GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         gap       <= '0;
         retry_req <= 1'b0;
         retry_tag <= '0;
      end else begin
         state     <= state_d;
         gap       <= gap_d;
         retry_req <= fire;
         if (fire) retry_tag <= c_tag;
      end
   end

endmodule

// File: tb/tb_mrc_sign_ec_resolve.sv
// Directed bench for mrc_sign_ec_resolve: vector table for classification/latency,
// plus hand-written sequences for retry spacing, FIFO overflow, clear and reset.
module tb_mrc_sign_ec_resolve;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [17:0] d4_0_8_;
   logic [1:0]  Sgn_in_9_A, Sgn_in_9_B;
   logic [7:0]  tag_in;
   logic        clr_cnt;
   logic        out_ready;
   logic        out_valid;
   logic [17:0] out_digit;
   logic [1:0]  out_sign, out_err;
   logic [7:0]  out_tag;
   logic        retry_req;
   logic [7:0]  retry_tag;
   logic [15:0] err_count, drop_count;
   logic        ovf_sticky;

   int total = 0;
   int bad   = 0;

   mrc_sign_ec_resolve #(
      .DATA_WIDTH(18), .TAG_WIDTH(8), .FIFO_AW(3), .CNT_WIDTH(16), .RETRY_GAP(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .d4_0_8_(d4_0_8_),
      .Sgn_in_9_A(Sgn_in_9_A), .Sgn_in_9_B(Sgn_in_9_B), .tag_in(tag_in),
      .clr_cnt(clr_cnt), .out_ready(out_ready), .out_valid(out_valid),
      .out_digit(out_digit), .out_sign(out_sign), .out_err(out_err), .out_tag(out_tag),
      .retry_req(retry_req), .retry_tag(retry_tag), .err_count(err_count),
      .drop_count(drop_count), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  a, b;
      logic [17:0] d;
      logic [7:0]  tag;
      logic [1:0]  sign, err;
      logic        retry;
   } vec_t;

   vec_t vt [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic [17:0] d, input logic [7:0] t);
      in_valid   = v;
      Sgn_in_9_A = a;
      Sgn_in_9_B = b;
      d4_0_8_    = d;
      tag_in     = t;
   endtask

   initial begin
      int pulses, first_cyc, second_cyc;
      logic [7:0] first_tag, second_tag;

      vt[0] = '{2'b01, 2'b01, 18'h01234, 8'h05, 2'b01, 2'b00, 1'b0};
      vt[1] = '{2'b10, 2'b10, 18'h3ffff, 8'hff, 2'b10, 2'b00, 1'b0};
      vt[2] = '{2'b00, 2'b00, 18'h00000, 8'h00, 2'b00, 2'b00, 1'b0};
      vt[3] = '{2'b11, 2'b11, 18'h2aaaa, 8'h11, 2'b11, 2'b10, 1'b0};
      vt[4] = '{2'b01, 2'b10, 18'h00001, 8'h07, 2'b11, 2'b01, 1'b1};
      vt[5] = '{2'b10, 2'b10, 18'h15555, 8'h23, 2'b10, 2'b00, 1'b0};
      vt[6] = '{2'b00, 2'b11, 18'h0beef, 8'h42, 2'b11, 2'b01, 1'b1};

      reset_n = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_retry_req", retry_req, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_digit", out_digit, 0);
      reset_n = 1'b1;
      tick();

      // classification / latency table
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, vt[i].a, vt[i].b, vt[i].d, vt[i].tag);
         tick();
         in_valid = 1'b0;
         chk("lat_early_valid", out_valid, 0);
         tick();
         chk("vec_valid", out_valid, 1);
         chk("vec_sign", out_sign, vt[i].sign);
         chk("vec_err", out_err, vt[i].err);
         chk("vec_digit", out_digit, vt[i].d);
         chk("vec_tag", out_tag, vt[i].tag);
         chk("vec_retry", retry_req, vt[i].retry);
         if (vt[i].retry) chk("vec_retry_tag", retry_tag, vt[i].tag);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("vec_popped", out_valid, 0);
      end
      chk("table_err_count", err_count, 3);

      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
      chk("clr_err_count", err_count, 0);
      repeat (6) tick();

      // retry rate limiting: errors at cycles 0..3 then 10
      out_ready = 1'b1;
      pulses = 0; first_cyc = 0; second_cyc = 0; first_tag = '0; second_tag = '0;
      for (int c = 0; c < 16; c++) begin
         if (c < 4)       drive(1'b1, 2'b01, 2'b10, 18'(c), 8'(c + 1));
         else if (c == 10) drive(1'b1, 2'b10, 2'b01, 18'h00abc, 8'h05);
         else             drive(1'b0, 2'b00, 2'b00, '0, '0);
         tick();
         if (retry_req) begin
            pulses++;
            if (pulses == 1) begin first_cyc = c; first_tag = retry_tag; end
            else begin second_cyc = c; second_tag = retry_tag; end
         end
      end
      chk("retry_pulses", pulses, 2);
      chk("retry_first_tag", first_tag, 8'h01);
      chk("retry_second_tag", second_tag, 8'h05);
      chk("retry_spacing_ge4", (second_cyc - first_cyc) >= 4, 1);
      chk("burst_err_count", err_count, 5);
      chk("burst_drained", out_valid, 0);

      // overflow: 10 pushes into depth-8 FIFO with no pops
      out_ready = 1'b0;
      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'b01, 2'b01, 18'(i), 8'(8'h30 + i));
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("ovf_drop_count", drop_count, 2);
      chk("ovf_sticky", ovf_sticky, 1);
      chk("ovf_err_count", err_count, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_tag", out_tag, 8'h30 + i);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", out_valid, 0);

      // full FIFO with simultaneous push and pop
      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
      chk("clr_ovf", ovf_sticky, 0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'b10, 2'b10, 18'(i), 8'(8'h50 + i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      drive(1'b1, 2'b10, 2'b10, 18'h00008, 8'h58);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_drop_count", drop_count, 0);
      chk("pp_ovf", ovf_sticky, 0);
      chk("pp_head_tag", out_tag, 8'h51);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("pp_drain_tag", out_tag, 8'h51 + i);
         tick();
      end
      out_ready = 1'b0;
      chk("pp_occupancy8", out_valid, 0);

      // clear coinciding with an error event
      drive(1'b1, 2'b01, 2'b10, 18'h00111, 8'h70);
      tick();
      chk("pre_clr_err_count", err_count, 1);
      drive(1'b1, 2'b01, 2'b10, 18'h00222, 8'h71);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0; in_valid = 1'b0;
      chk("clr_coincident_err", err_count, 1);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      repeat (8) tick();

      // reset mid-operation with entries queued and a retry pulse live
      for (int i = 0; i < 4; i++) begin
         if (i == 3) drive(1'b1, 2'b01, 2'b10, 18'(i), 8'(8'h60 + i));
         else        drive(1'b1, 2'b01, 2'b01, 18'(i), 8'(8'h60 + i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("prerst_retry", retry_req, 1);
      chk("prerst_valid", out_valid, 1);
      chk("prerst_err_count", err_count, 2);
      reset_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_retry", retry_req, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_drop_count", drop_count, 0);
      chk("arst_tag", out_tag, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("postrst_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
